// File: rtl/snowv_ctrl.sv
// SNOW-V keystream sequencer: key/IV load, INIT_ROUNDS init rounds, then valid/ready block streaming.
// Latency: first ks_valid at 2+INIT_ROUNDS*ROUND_CYCLES after start; one block per ROUND_CYCLES under full rate.
// Backpressure: ks_valid holds until ks_ready. SNOWV_KS_LIMIT_EN parks the stream after MAX_BLOCKS blocks.
module snowv_ctrl #(
  parameter int ROUND_CYCLES = 2,
  parameter int INIT_ROUNDS  = 16,
  parameter int CNT_W        = 32,
  parameter int MAX_BLOCKS   = 2**20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_init_mode,
  output logic             dp_r1_xor_klo,
  output logic             dp_r1_xor_khi,
  output logic [3:0]       round_idx,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             limit
);

`ifdef SNOWV_KS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam bit               FAST        = (ROUND_CYCLES == 1);
  localparam logic [3:0]       SETTLE_LAST = (ROUND_CYCLES > 1) ? 4'(ROUND_CYCLES - 2) : 4'd0;
  localparam logic [3:0]       KLO_IDX     = 4'(INIT_ROUNDS - 2);
  localparam logic [3:0]       KHI_IDX     = 4'(INIT_ROUNDS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_BLOCKS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT_STEP,
    INIT_WAIT,
    KS_WAIT,
    KS_VALID
  } state_t;

  state_t           state;
  logic             step_q;
  logic             limit_q;
  logic [3:0]       wait_cnt;
  logic [3:0]       rnd_nxt;
  logic [CNT_W-1:0] blk_nxt;
  logic             hs;
  logic             hs_step;
  logic             do_load;
  logic             settle_done;

  assign hs      = ks_valid & ks_ready;
  assign do_load = start & ((state == IDLE) | (state == KS_WAIT) | (state == KS_VALID));
  assign rnd_nxt = round_idx + 4'd1;
  assign blk_nxt = blk_cnt + CNT_W'(1);

  // The consumed block must advance the datapath on the very edge that accepts it,
  // so the handshake step is the one output term that looks at live inputs.
  assign hs_step = hs & ~start & ~abort;
  assign dp_step = step_q | hs_step;
  assign limit   = limit_q;

  assign settle_done = ((state == INIT_STEP) & FAST) |
                       ((state == INIT_WAIT) & (wait_cnt == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      ks_valid      <= 1'b0;
      dp_load       <= 1'b0;
      step_q        <= 1'b0;
      dp_init_mode  <= 1'b0;
      dp_r1_xor_klo <= 1'b0;
      dp_r1_xor_khi <= 1'b0;
      round_idx     <= 4'd0;
      blk_cnt       <= '0;
      limit_q       <= 1'b0;
      wait_cnt      <= 4'd0;
    end else begin
      dp_load       <= 1'b0;
      step_q        <= 1'b0;
      dp_r1_xor_klo <= 1'b0;
      dp_r1_xor_khi <= 1'b0;

      if (abort) begin
        state        <= IDLE;
        busy         <= 1'b0;
        ks_valid     <= 1'b0;
        dp_init_mode <= 1'b0;
        round_idx    <= 4'd0;
        limit_q      <= 1'b0;
        wait_cnt     <= 4'd0;
      end else if (do_load) begin
        state        <= LOAD;
        busy         <= 1'b1;
        ks_valid     <= 1'b0;
        dp_load      <= 1'b1;
        dp_init_mode <= 1'b0;
        round_idx    <= 4'd0;
        blk_cnt      <= '0;
        limit_q      <= 1'b0;
        wait_cnt     <= 4'd0;
      end else begin
        case (state)
          IDLE: ;

          LOAD: begin
            state         <= INIT_STEP;
            step_q        <= 1'b1;
            dp_init_mode  <= 1'b1;
            round_idx     <= 4'd0;
            dp_r1_xor_klo <= (KLO_IDX == 4'd0);
            dp_r1_xor_khi <= (KHI_IDX == 4'd0);
          end

          INIT_STEP, INIT_WAIT: begin
            if (settle_done) begin
              // The settle of the final init round doubles as the first keystream settle.
              if (round_idx == KHI_IDX) begin
                state        <= KS_VALID;
                ks_valid     <= 1'b1;
                dp_init_mode <= 1'b0;
              end else begin
                state         <= INIT_STEP;
                step_q        <= 1'b1;
                round_idx     <= rnd_nxt;
                dp_r1_xor_klo <= (rnd_nxt == KLO_IDX);
                dp_r1_xor_khi <= (rnd_nxt == KHI_IDX);
              end
            end else if (state == INIT_STEP) begin
              state    <= INIT_WAIT;
              wait_cnt <= SETTLE_LAST;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end

          KS_WAIT: begin
            if (!limit_q) begin
              if (wait_cnt == 4'd0) begin
                state    <= KS_VALID;
                ks_valid <= 1'b1;
              end else begin
                wait_cnt <= wait_cnt - 4'd1;
              end
            end
          end

          KS_VALID: begin
            if (hs) begin
              blk_cnt <= blk_nxt;
              if (LIMIT_EN && (blk_nxt == MAX_CNT)) begin
                state    <= KS_WAIT;
                ks_valid <= 1'b0;
                limit_q  <= 1'b1;
              end else if (!FAST) begin
                state    <= KS_WAIT;
                ks_valid <= 1'b0;
                wait_cnt <= SETTLE_LAST;
              end
            end
          end

          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            ks_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snowv_ctrl.sv
// Directed bench for snowv_ctrl with ROUND_CYCLES=2, INIT_ROUNDS=16, MAX_BLOCKS=4.
module tb_snowv_ctrl;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          ks_ready;
  logic          busy;
  logic          ks_valid;
  logic          dp_load;
  logic          dp_step;
  logic          dp_init_mode;
  logic          klo;
  logic          khi;
  logic [3:0]    round_idx;
  logic [CW-1:0] blk_cnt;
  logic          limit;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int hs_n;
  int step_n;
  bit pv;
  bit pr;

  always #5 clk = ~clk;

  snowv_ctrl #(
    .ROUND_CYCLES(2),
    .INIT_ROUNDS (16),
    .CNT_W       (CW),
    .MAX_BLOCKS  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .ks_valid     (ks_valid),
    .ks_ready     (ks_ready),
    .dp_load      (dp_load),
    .dp_step      (dp_step),
    .dp_init_mode (dp_init_mode),
    .dp_r1_xor_klo(klo),
    .dp_r1_xor_khi(khi),
    .round_idx    (round_idx),
    .blk_cnt      (blk_cnt),
    .limit        (limit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Caller is at cycle 0 of a sequence; start pulses here and optionally again at start_at.
  task automatic init_seq(input int start_at);
    start = 1'b1;
    #1;
    tick(); start = 1'b0; #1;
    chk("load", dp_load, 1);
    chk("load_busy", busy, 1);
    chk("load_nostep", dp_step, 0);
    chk("load_blk", blk_cnt, 0);
    for (int c = 2; c <= 33; c++) begin
      tick(); start = (c == start_at); #1;
      chk("init_step", dp_step, ((c % 2) == 0));
      chk("init_mode", dp_init_mode, 1);
      chk("init_klo", klo, (c == 30));
      chk("init_khi", khi, (c == 32));
      chk("init_ridx", round_idx, (c - 2) / 2);
      chk("init_noload", dp_load, 0);
      chk("init_novalid", ks_valid, 0);
    end
    tick(); start = 1'b0; #1;
    chk("valid_34", ks_valid, 1);
    chk("mode_off_34", dp_init_mode, 0);
    chk("nostep_34", dp_step, 0);
    chk("blk_34", blk_cnt, 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (ks_valid !== 1'b1 && n < 100) begin
      tick(); #1;
      n++;
    end
    chk(tag, ks_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    ks_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", ks_valid, 0);
    chk("rst_load", dp_load, 0);
    chk("rst_step", dp_step, 0);
    chk("rst_mode", dp_init_mode, 0);
    chk("rst_klo", klo, 0);
    chk("rst_khi", khi, 0);
    chk("rst_ridx", round_idx, 0);
    chk("rst_blk", blk_cnt, 0);
    chk("rst_limit", limit, 0);
    rst = 1'b0;
    tick(); tick(); #1;
    chk("idle_busy", busy, 0);

    // Full init with the consumer stalled
    tick();
    init_seq(-1);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk("hold_valid", ks_valid, 1);
      chk("hold_nostep", dp_step, 0);
    end

    // Consumer at full rate: step with each handshake, one block every two cycles
    tick(); ks_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hs_valid", ks_valid, 1);
      chk("hs_step", dp_step, 1);
      chk("hs_blk", blk_cnt, k);
      tick(); #1;
      chk("gap_valid", ks_valid, 0);
      chk("gap_step", dp_step, 0);
      chk("gap_blk", blk_cnt, k + 1);
      tick();
    end
    ks_ready = 1'b0; #1;
    chk("after3_valid", ks_valid, 1);
    chk("after3_step", dp_step, 0);
    chk("after3_blk", blk_cnt, 3);

    // Random ready: valid never drops unconsumed, steps match handshakes
    hs_n = 0; step_n = 0; pv = 1'b1; pr = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(); ks_ready = 1'($urandom_range(0, 1)); #1;
      if (pv && !pr) chk("no_drop", ks_valid, 1);
      if (pv && pr) chk("gap_after_hs", ks_valid, 0);
      chk("step_eq_hs", dp_step, ks_valid & ks_ready);
      if (ks_valid && ks_ready) hs_n++;
      if (dp_step) step_n++;
      pv = ks_valid; pr = ks_ready;
    end
    tick(); ks_ready = 1'b0; #1;
    chk("rand_blk", blk_cnt, 3 + hs_n);
    chk("rand_steps", step_n, hs_n);

    // Rekey coinciding with a handshake
    wait_valid("wait_rekey");
    start = 1'b1; ks_ready = 1'b1; #1;
    chk("rekey_nostep", dp_step, 0);
    tick(); start = 1'b0; ks_ready = 1'b0; #1;
    chk("rekey_load", dp_load, 1);
    chk("rekey_blk", blk_cnt, 0);
    chk("rekey_novalid", ks_valid, 0);

    // Abort at cycle 20 of init
    for (int c = 2; c <= 19; c++) tick();
    tick(); abort = 1'b1; #1;
    chk("pre_abort_ridx", round_idx, 9);
    chk("pre_abort_busy", busy, 1);
    tick(); abort = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_mode", dp_init_mode, 0);
    chk("abort_ridx", round_idx, 0);
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      chk("idle_nostep", dp_step, 0);
      chk("idle_noload", dp_load, 0);
      chk("idle_nobusy", busy, 0);
    end

    // Restart; a start during init must be ignored
    tick();
    init_seq(10);
    ks_ready = 1'b1; #1;
    chk("hs1_step", dp_step, 1);
    tick(); ks_ready = 1'b0; #1;
    chk("hs1_blk", blk_cnt, 1);
    tick(); #1;
    chk("hs2_valid", ks_valid, 1);

    // abort beats start and a handshake; blk_cnt is held
    abort = 1'b1; start = 1'b1; ks_ready = 1'b1; #1;
    chk("abort_hs_nostep", dp_step, 0);
    tick(); abort = 1'b0; start = 1'b0; ks_ready = 1'b0; #1;
    chk("abort2_busy", busy, 0);
    chk("abort2_noload", dp_load, 0);
    chk("abort2_blk", blk_cnt, 1);
    chk("abort2_novalid", ks_valid, 0);
    tick(); #1;
    chk("abort2_still_idle", busy, 0);

    // Block limit (or unbounded stream without the limit build)
    tick();
    init_seq(-1);
    hs_n = 0; step_n = 0;
    ks_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ks_valid && ks_ready) hs_n++;
      if (dp_step) step_n++;
      tick();
    end
    #1;
    chk("lim_steps", step_n, hs_n);
`ifdef SNOWV_KS_LIMIT_EN
    chk("lim_hs", hs_n, 4);
    chk("lim_flag", limit, 1);
    chk("lim_novalid", ks_valid, 0);
    chk("lim_blk", blk_cnt, 4);
    chk("lim_nostep", dp_step, 0);
`else
    chk("unl_hs", hs_n, 20);
    chk("unl_flag", limit, 0);
    chk("unl_blk", blk_cnt, 20);
`endif
    start = 1'b1;
    tick(); start = 1'b0; ks_ready = 1'b0; #1;
    chk("relim_load", dp_load, 1);
    chk("relim_flag", limit, 0);
    chk("relim_blk", blk_cnt, 0);
    tick(); #1;
    chk("relim_step", dp_step, 1);
    chk("relim_mode", dp_init_mode, 1);
    chk("relim_ridx", round_idx, 0);

    // Asynchronous reset mid-init
    repeat (7) tick();
    rst = 1'b1; #1;
    chk("arst_busy", busy, 0);
    chk("arst_step", dp_step, 0);
    chk("arst_mode", dp_init_mode, 0);
    chk("arst_ridx", round_idx, 0);
    chk("arst_blk", blk_cnt, 0);
    tick(); rst = 1'b0; #1;
    chk("arst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
